// File: rtl/ceespu_fetch_pc_pkg.sv
// Shared types and default constants for the ceespu fetch-stage program counter.
package ceespu_pkg;

   localparam int DEFAULT_PC_WIDTH   = 14;
   localparam int DEFAULT_RAS_DEPTH  = 4;
   localparam int DEFAULT_IRQ_VECTOR = 16;

   localparam logic [DEFAULT_PC_WIDTH-1:0] DEFAULT_RESET_VECTOR = '1;

   typedef enum logic [2:0] {
      PCSEL_HOLD,
      PCSEL_INC,
      PCSEL_BRANCH,
      PCSEL_RET,
      PCSEL_IRQ
   } pc_sel_e;

endpackage

// File: rtl/ceespu_fetch_pc_if.sv
// Execute-stage requests into the PC unit and fetch-address/status outputs back out.
interface ceespu_fetch_pc_if
   import ceespu_pkg::*;
#(
   parameter int PC_WIDTH = DEFAULT_PC_WIDTH
);

   logic                I_stall;
   logic                I_branch;
   logic                I_call;
   logic                I_ret;
   logic [PC_WIDTH-1:0] I_branchAddress;
   logic                I_irq;

   logic [PC_WIDTH-1:0] O_PC;
   logic                O_irq_ack;
   logic                O_ras_empty;
   logic                O_ras_overflow;
   logic                O_ras_underflow;

   modport master (
      output I_stall, I_branch, I_call, I_ret, I_branchAddress, I_irq,
      input  O_PC, O_irq_ack, O_ras_empty, O_ras_overflow, O_ras_underflow
   );

   modport slave (
      input  I_stall, I_branch, I_call, I_ret, I_branchAddress, I_irq,
      output O_PC, O_irq_ack, O_ras_empty, O_ras_overflow, O_ras_underflow
   );

endinterface

// File: rtl/ceespu_fetch_pc_ras.sv
// Circular return-address stack: a full push overwrites the oldest entry, pop returns the newest.
module ceespu_ras
   import ceespu_pkg::*;
#(
   parameter int WIDTH = DEFAULT_PC_WIDTH,
   parameter int DEPTH = DEFAULT_RAS_DEPTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] push_data,
   output logic [WIDTH-1:0] top,
   output logic             empty,
   output logic             overflow,
   output logic             underflow
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [PTR_W-1:0] PTR_ONE  = 1;
   localparam logic [CNT_W-1:0] CNT_ONE  = 1;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wptr_q, wptr_d;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count_q, count_d;
   logic             empty_q, empty_d;
   logic             over_q, over_d;
   logic             under_q, under_d;
   logic             full;

   // The newest entry sits just below the write pointer; the pointer wraps because DEPTH is a power of two.
   assign rd_ptr = wptr_q - PTR_ONE;
   assign full   = (count_q == CNT_FULL);

   always_comb begin
      mem_d   = mem_q;
      wptr_d  = wptr_q;
      count_d = count_q;
      over_d  = over_q;
      under_d = under_q;
      if (push) begin
         mem_d[wptr_q] = push_data;
         wptr_d        = wptr_q + PTR_ONE;
         if (full) begin
            over_d = 1'b1;
         end else begin
            count_d = count_q + CNT_ONE;
         end
      end else if (pop) begin
         if (count_q == '0) begin
            under_d = 1'b1;
         end else begin
            wptr_d  = rd_ptr;
            count_d = count_q - CNT_ONE;
         end
      end
      empty_d = (count_d == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q   <= '{default: '0};
         wptr_q  <= '0;
         count_q <= '0;
         empty_q <= 1'b1;
         over_q  <= 1'b0;
         under_q <= 1'b0;
      end else begin
         mem_q   <= mem_d;
         wptr_q  <= wptr_d;
         count_q <= count_d;
         empty_q <= empty_d;
         over_q  <= over_d;
         under_q <= under_d;
      end
   end

   assign top       = mem_q[rd_ptr];
   assign empty     = empty_q;
   assign overflow  = over_q;
   assign underflow = under_q;

endmodule

// File: rtl/ceespu_fetch_pc.sv
// Fetch program counter with branch/call/return, a return-address stack and an interrupt vector.
module ceespu_fetch_pc
   import ceespu_pkg::*;
#(
   parameter int                  PC_WIDTH     = DEFAULT_PC_WIDTH,
   parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '1,
   parameter logic [PC_WIDTH-1:0] IRQ_VECTOR   = PC_WIDTH'(DEFAULT_IRQ_VECTOR),
   parameter int                  RAS_DEPTH    = DEFAULT_RAS_DEPTH
) (
   input  logic               I_clk,
   input  logic               I_rst_n,
   ceespu_fetch_pc_if.slave   bus
);

   localparam logic [PC_WIDTH-1:0] PC_ONE = 1;

   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic [PC_WIDTH-1:0] pc_inc;
   logic                pend_q, pend_d;
   logic                ack_q, ack_d;
   logic                irq_take;
   pc_sel_e             pc_sel;

   logic                ras_push;
   logic                ras_pop;
   logic [PC_WIDTH-1:0] ras_top;
   logic                ras_empty;
   logic                ras_overflow;
   logic                ras_underflow;

   assign pc_inc = pc_q + PC_ONE;

   // One action per edge: branch, then return, then interrupt, then increment, else hold.
   always_comb begin
      pc_sel   = PCSEL_HOLD;
      ras_push = 1'b0;
      ras_pop  = 1'b0;
      irq_take = 1'b0;
      if (bus.I_branch) begin
         pc_sel   = PCSEL_BRANCH;
         ras_push = bus.I_call;
      end else if (bus.I_ret) begin
         ras_pop = 1'b1;
         pc_sel  = ras_empty ? PCSEL_INC : PCSEL_RET;
      end else if (pend_q && !bus.I_stall) begin
         pc_sel   = PCSEL_IRQ;
         ras_push = 1'b1;
         irq_take = 1'b1;
      end else if (!bus.I_stall) begin
         pc_sel = PCSEL_INC;
      end
   end

   always_comb begin
      pc_d = pc_q;
      case (pc_sel)
         PCSEL_INC:    pc_d = pc_inc;
         PCSEL_BRANCH: pc_d = bus.I_branchAddress;
         PCSEL_RET:    pc_d = ras_top;
         PCSEL_IRQ:    pc_d = IRQ_VECTOR;
         default:      pc_d = pc_q;
      endcase
   end

   // Taking the interrupt clears pending even if the request line is still high on that edge.
   always_comb begin
      pend_d = irq_take ? 1'b0 : (pend_q | bus.I_irq);
      ack_d  = irq_take;
   end

   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         pc_q   <= RESET_VECTOR;
         pend_q <= 1'b0;
         ack_q  <= 1'b0;
      end else begin
         pc_q   <= pc_d;
         pend_q <= pend_d;
         ack_q  <= ack_d;
      end
   end

   ceespu_ras #(
      .WIDTH (PC_WIDTH),
      .DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (I_clk),
      .rst_n     (I_rst_n),
      .push      (ras_push),
      .pop       (ras_pop),
      .push_data (pc_inc),
      .top       (ras_top),
      .empty     (ras_empty),
      .overflow  (ras_overflow),
      .underflow (ras_underflow)
   );

   assign bus.O_PC            = pc_q;
   assign bus.O_irq_ack       = ack_q;
   assign bus.O_ras_empty     = ras_empty;
   assign bus.O_ras_overflow  = ras_overflow;
   assign bus.O_ras_underflow = ras_underflow;

endmodule

// File: tb/tb_ceespu_fetch_pc.sv
// Table-driven and randomized checks of ceespu_fetch_pc against a queue-based reference model.
module tb_ceespu_fetch_pc;

   localparam int PW    = 14;
   localparam int DEPTH = 4;
   localparam int IRQV  = 16;

   logic I_clk   = 1'b0;
   logic I_rst_n = 1'b1;

   ceespu_fetch_pc_if #(.PC_WIDTH(PW)) bus ();

   ceespu_fetch_pc #(
      .PC_WIDTH     (PW),
      .RESET_VECTOR ({PW{1'b1}}),
      .IRQ_VECTOR   (PW'(IRQV)),
      .RAS_DEPTH    (DEPTH)
   ) dut (
      .I_clk   (I_clk),
      .I_rst_n (I_rst_n),
      .bus     (bus)
   );

   always #5 I_clk = ~I_clk;

   int errors = 0;
   int checks = 0;

   // Reference model: PC value, return stack as a queue (back = newest), pending bit, flags.
   logic [PW-1:0] m_pc;
   logic [PW-1:0] m_ras[$];
   bit            m_pend;
   bit            m_ack;
   bit            m_of;
   bit            m_uf;

   typedef struct {
      bit            stall;
      bit            branch;
      bit            call;
      bit            ret;
      bit            irq;
      logic [PW-1:0] addr;
      int            pc;
      bit            ack;
      bit            empty;
      bit            of;
      bit            uf;
   } vec_t;

   vec_t vecs[$];

   function automatic void addVec(bit s, bit b, bit c, bit r, bit q, int addr,
                                  int pc, bit ack, bit empty, bit of, bit uf);
      vec_t v;
      v.stall  = s;
      v.branch = b;
      v.call   = c;
      v.ret    = r;
      v.irq    = q;
      v.addr   = addr[PW-1:0];
      v.pc     = pc;
      v.ack    = ack;
      v.empty  = empty;
      v.of     = of;
      v.uf     = uf;
      vecs.push_back(v);
   endfunction

   task automatic check(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic modelReset();
      m_pc   = '1;
      m_ras.delete();
      m_pend = 1'b0;
      m_ack  = 1'b0;
      m_of   = 1'b0;
      m_uf   = 1'b0;
   endtask

   task automatic modelPush(logic [PW-1:0] v);
      if (m_ras.size() == DEPTH) begin
         void'(m_ras.pop_front());
         m_of = 1'b1;
      end
      m_ras.push_back(v);
   endtask

   task automatic modelStep(bit s, bit b, bit c, bit r, bit q, logic [PW-1:0] addr);
      logic [PW-1:0] nxt;
      bit            take;
      nxt   = m_pc + 14'd1;
      take  = 1'b0;
      m_ack = 1'b0;
      if (b) begin
         if (c) modelPush(nxt);
         m_pc = addr;
      end else if (r) begin
         if (m_ras.size() > 0) begin
            m_pc = m_ras.pop_back();
         end else begin
            m_pc = nxt;
            m_uf = 1'b1;
         end
      end else if (m_pend && !s) begin
         modelPush(nxt);
         m_pc  = PW'(IRQV);
         take  = 1'b1;
         m_ack = 1'b1;
      end else if (!s) begin
         m_pc = nxt;
      end
      m_pend = take ? 1'b0 : (m_pend | q);
   endtask

   // Called just after a falling edge; inputs settle, one rising edge happens, returns on the next falling edge.
   task automatic applyStimulus(bit s, bit b, bit c, bit r, bit q, logic [PW-1:0] addr);
      bus.I_stall         = s;
      bus.I_branch        = b;
      bus.I_call          = c;
      bus.I_ret           = r;
      bus.I_irq           = q;
      bus.I_branchAddress = addr;
      @(posedge I_clk);
      modelStep(s, b, c, r, q, addr);
      @(negedge I_clk);
   endtask

   task automatic checkOutput(string tag, int pc, bit ack, bit empty, bit of, bit uf);
      check({tag, ".pc"},        int'(bus.O_PC),            pc);
      check({tag, ".irq_ack"},   int'(bus.O_irq_ack),       int'(ack));
      check({tag, ".empty"},     int'(bus.O_ras_empty),     int'(empty));
      check({tag, ".overflow"},  int'(bus.O_ras_overflow),  int'(of));
      check({tag, ".underflow"}, int'(bus.O_ras_underflow), int'(uf));
   endtask

   task automatic checkModel(string tag);
      checkOutput(tag, int'(m_pc), m_ack, (m_ras.size() == 0), m_of, m_uf);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bus.I_stall         = 1'b0;
      bus.I_branch        = 1'b0;
      bus.I_call          = 1'b0;
      bus.I_ret           = 1'b0;
      bus.I_irq           = 1'b0;
      bus.I_branchAddress = '0;
      modelReset();

      // Stall/branch/call/ret/irq, addr -> pc, ack, empty, overflow, underflow.
      addVec(0,0,0,0,0,   0,     0, 0,1,0,0);
      addVec(0,0,0,0,0,   0,     1, 0,1,0,0);
      addVec(0,0,0,0,0,   0,     2, 0,1,0,0);
      addVec(0,0,0,0,0,   0,     3, 0,1,0,0);
      addVec(0,0,0,0,0,   0,     4, 0,1,0,0);
      addVec(0,0,0,0,0,   0,     5, 0,1,0,0);
      addVec(1,1,0,0,0, 256,   256, 0,1,0,0);
      addVec(1,0,0,0,0,   0,   256, 0,1,0,0);
      addVec(0,1,0,0,0,  10,    10, 0,1,0,0);
      addVec(0,1,1,0,0, 200,   200, 0,0,0,0);
      addVec(0,0,0,0,0,   0,   201, 0,0,0,0);
      addVec(0,0,0,0,0,   0,   202, 0,0,0,0);
      addVec(1,0,0,1,0,   0,    11, 0,1,0,0);
      addVec(0,0,1,0,0, 900,    12, 0,1,0,0);
      addVec(0,1,0,0,0,   1,     1, 0,1,0,0);
      addVec(0,1,1,0,0,   2,     2, 0,0,0,0);
      addVec(0,1,1,0,0,   3,     3, 0,0,0,0);
      addVec(0,1,1,0,0,   4,     4, 0,0,0,0);
      addVec(0,1,1,0,0,   5,     5, 0,0,0,0);
      addVec(0,1,1,0,0, 100,   100, 0,0,1,0);
      addVec(0,0,0,1,0,   0,     6, 0,0,1,0);
      addVec(0,0,0,1,0,   0,     5, 0,0,1,0);
      addVec(0,0,0,1,0,   0,     4, 0,0,1,0);
      addVec(0,0,0,1,0,   0,     3, 0,1,1,0);
      addVec(0,0,0,1,0,   0,     4, 0,1,1,1);
      addVec(0,1,0,0,0,   7,     7, 0,1,1,1);
      addVec(1,0,0,0,1,   0,     7, 0,1,1,1);
      addVec(1,0,0,0,0,   0,     7, 0,1,1,1);
      addVec(0,0,0,0,0,   0,    16, 1,0,1,1);
      addVec(0,0,0,0,0,   0,    17, 0,0,1,1);
      addVec(0,0,0,1,0,   0,     8, 0,1,1,1);
      addVec(0,1,0,0,0,  30,    30, 0,1,1,1);
      addVec(0,1,0,0,1,  50,    50, 0,1,1,1);
      addVec(0,0,0,0,0,   0,    16, 1,0,1,1);
      addVec(0,0,0,0,0,   0,    17, 0,0,1,1);

      #1 I_rst_n = 1'b0;
      #1 checkOutput("reset", 16383, 0, 1, 0, 0);
      @(negedge I_clk);
      @(negedge I_clk);
      I_rst_n = 1'b1;
      #1 checkOutput("release", 16383, 0, 1, 0, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].stall, vecs[i].branch, vecs[i].call,
                       vecs[i].ret, vecs[i].irq, vecs[i].addr);
         checkOutput($sformatf("vec%0d", i), vecs[i].pc, vecs[i].ack,
                     vecs[i].empty, vecs[i].of, vecs[i].uf);
      end

      // Mid-handler reset must take effect without a clock edge.
      #2 I_rst_n = 1'b0;
      #1 checkOutput("async_reset", 16383, 0, 1, 0, 0);
      modelReset();
      @(negedge I_clk);
      @(negedge I_clk);
      I_rst_n = 1'b1;
      #1;
      applyStimulus(0, 0, 0, 0, 0, '0);
      checkOutput("wrap_after_reset", 0, 0, 1, 0, 0);

      // Level-held request: ack, then pending re-set on the next edge, then taken again.
      applyStimulus(0, 0, 0, 0, 1, '0);
      checkModel("irq_level_a");
      applyStimulus(0, 0, 0, 0, 1, '0);
      checkModel("irq_level_b");
      applyStimulus(0, 0, 0, 0, 1, '0);
      checkModel("irq_level_c");
      applyStimulus(0, 0, 0, 0, 0, '0);
      checkModel("irq_level_d");

      for (int i = 0; i < 400; i++) begin
         bit            s, b, c, r, q;
         logic [PW-1:0] addr;
         s = ($urandom % 4) == 0;
         b = ($urandom % 6) == 0;
         c = ($urandom % 2) == 0;
         r = ($urandom % 6) == 0;
         q = ($urandom % 10) == 0;
         if (($urandom % 4) == 0) begin
            addr = PW'(16383 - $urandom_range(0, 3));
         end else begin
            addr = PW'($urandom_range(0, 16383));
         end
         applyStimulus(s, b, c, r, q, addr);
         checkModel($sformatf("rand%0d", i));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
